// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU opcode encodings and opcode-class helpers.
// The MADD/MADDU/MSUB/MSUBU group exists only when MDU_MADD_EN is defined.
package mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
`ifdef MDU_MADD_EN
    ,
    MDU_MADD  = 4'd9,
    MDU_MADDU = 4'd10,
    MDU_MSUB  = 4'd11,
    MDU_MSUBU = 4'd12
`endif
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_div_op(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Opcodes that occupy the unit for a countdown; anything else never starts.
  function automatic logic is_start_op(input mdu_op_e op);
    logic r;
    r = 1'b0;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage <-> MDU bundle: opcode, qualified start, flush request, operands, busy and read data.
// master drives the request side, slave (the MDU) returns busy/result.
interface mdu_ctrl_if;
  import mdu_ctrl_pkg::*;

  mdu_op_e     mduOp;
  logic        start;
  logic        req;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic [31:0] mduRes;

  modport master (output mduOp, start, req, srcA, srcB, input busy, mduRes);
  modport slave  (input mduOp, start, req, srcA, srcB, output busy, mduRes);
endinterface

// File: rtl/mdu_calc.sv
// Combinational MDU datapath: full 64-bit mult, truncating div, div-by-zero keeps HI/LO.
// Zero latency, no backpressure; multiply-accumulate ops only when MDU_MADD_EN is defined.
module mdu_calc
  import mdu_ctrl_pkg::*;
(
  input  mdu_op_e     mdu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] div_u;
  logic [31:0] div_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic        b_zero;

  always_comb begin
    prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    prod_u = {32'd0, src_a} * {32'd0, src_b};
    b_zero = (src_b == 32'd0);
    abs_a  = src_a[31] ? (32'd0 - src_a) : src_a;
    abs_b  = src_b[31] ? (32'd0 - src_b) : src_b;
    // Divisors are forced non-zero so the dividers never see 0; the result is discarded then.
    div_u  = b_zero ? 32'd1 : src_b;
    div_s  = b_zero ? 32'd1 : abs_b;
    // Signed divide on magnitudes makes 0x80000000 / -1 wrap to 0x80000000 with no remainder.
    quo_s  = abs_a / div_s;
    rem_s  = abs_a % div_s;
    if (src_a[31] ^ src_b[31]) quo_s = 32'd0 - quo_s;
    if (src_a[31])             rem_s = 32'd0 - rem_s;

    res_hi = hi;
    res_lo = lo;
    case (mdu_op)
      MDU_MULT:  {res_hi, res_lo} = prod_s;
      MDU_MULTU: {res_hi, res_lo} = prod_u;
      MDU_DIV: begin
        if (!b_zero) begin
          res_hi = rem_s;
          res_lo = quo_s;
        end
      end
      MDU_DIVU: begin
        if (!b_zero) begin
          res_hi = src_a % div_u;
          res_lo = src_a / div_u;
        end
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
      MDU_MADDU: {res_hi, res_lo} = {hi, lo} + prod_u;
      MDU_MSUB:  {res_hi, res_lo} = {hi, lo} - prod_s;
      MDU_MSUBU: {res_hi, res_lo} = {hi, lo} - prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer: HI/LO registers, pending result and fixed-latency countdown (MULT/DIV_CYCLES).
// No backpressure: starts while busy or flushed are dropped; the hazard unit stalls on start|busy.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  mdu_ctrl_if.slave   mdu
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic [31:0]      calc_hi, calc_lo;
  logic             accept;
  logic [31:0]      res;

  mdu_calc u_calc (
    .mdu_op (mdu.mduOp),
    .src_a  (mdu.srcA),
    .src_b  (mdu.srcB),
    .hi     (hi_q),
    .lo     (lo_q),
    .res_hi (calc_hi),
    .res_lo (calc_lo)
  );

  assign accept = mdu.start && !mdu.req && (state_q == S_IDLE) && is_start_op(mdu.mduOp);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          pend_hi_d = calc_hi;
          pend_lo_d = calc_lo;
          cnt_d     = is_div_op(mdu.mduOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_d   = S_RUN;
        end else if (!mdu.req && (mdu.mduOp == MDU_MTHI)) begin
          hi_d = mdu.srcA;
        end else if (!mdu.req && (mdu.mduOp == MDU_MTLO)) begin
          lo_d = mdu.srcA;
        end
      end
      S_RUN: begin
        // A flush never cancels the in-flight op; it belongs to an older instruction.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  always_comb begin
    res = 32'd0;
    case (mdu.mduOp)
      MDU_MFHI: res = hi_q;
      MDU_MFLO: res = lo_q;
      default:  res = 32'd0;
    endcase
  end

  assign mdu.busy   = (state_q == S_RUN);
  assign mdu.mduRes = res;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO and busy length queued at issue, checked at commit.
// Extra checks for MADD group when MDU_MADD_EN is defined.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_ctrl_if mdu ();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu)
  );

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    mdu.mduOp = MDU_NONE;
    mdu.start = 1'b0;
    mdu.req   = 1'b0;
    mdu.srcA  = 32'd0;
    mdu.srcB  = 32'd0;
  endtask

  task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b, input logic rq);
    mdu.mduOp = op;
    mdu.start = 1'b1;
    mdu.srcA  = a;
    mdu.srcB  = b;
    mdu.req   = rq;
    tick();
    idle_bus();
  endtask

  task automatic mt(input mdu_op_e op, input logic [31:0] val, input logic rq);
    mdu.mduOp = op;
    mdu.srcA  = val;
    mdu.req   = rq;
    tick();
    idle_bus();
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    mdu.mduOp = MDU_MFHI;
    #1 hi = mdu.mduRes;
    mdu.mduOp = MDU_MFLO;
    #1 lo = mdu.mduRes;
    mdu.mduOp = MDU_NONE;
    #1;
  endtask

  task automatic expect_op(input string tag, input logic [31:0] hi, input logic [31:0] lo, input int cyc);
    exp_t e;
    e.tag = tag;
    e.hi  = hi;
    e.lo  = lo;
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  // Counts remaining busy cycles, then pops the oldest expectation and checks it.
  task automatic wait_done();
    int          n;
    exp_t        e;
    logic [31:0] h, l;
    n = 0;
    while (mdu.busy && n < 200) begin
      n++;
      tick();
    end
    if (sb.size() == 0) begin
      check_eq("sb_underflow", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check_eq({e.tag, "_cyc"}, 32'(n), 32'(e.cyc));
    read_hilo(h, l);
    check_eq({e.tag, "_hi"}, h, e.hi);
    check_eq({e.tag, "_lo"}, l, e.lo);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] h, l, a, b;
    logic [63:0] p;
    longint      sa, sbv;
    int          ia, ib;

    idle_bus();
    reset = 1'b1;
    tick();
    tick();
    check_eq("rst_busy", {31'd0, mdu.busy}, 32'd0);
    check_eq("rst_res", mdu.mduRes, 32'd0);
    read_hilo(h, l);
    check_eq("rst_hi", h, 32'd0);
    check_eq("rst_lo", l, 32'd0);
    reset = 1'b0;
    tick();

    expect_op("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check_eq("mult_busy", {31'd0, mdu.busy}, 32'd1);
    wait_done();

    expect_op("multu", 32'h0000_0002, 32'hFFFF_FFFA, 5);
    issue(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_done();

    expect_op("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done();

    expect_op("divu_z", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(MDU_DIVU, 32'd7, 32'd0, 1'b0);
    wait_done();

    expect_op("div_ovf", 32'h0, 32'h8000_0000, 10);
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done();

    // Div issued two edges into a mult must be dropped.
    expect_op("mult_big", 32'd1, 32'd0, 3);
    issue(MDU_MULT, 32'h0001_0000, 32'h0001_0000, 1'b0);
    tick();
    issue(MDU_DIV, 32'd100, 32'd7, 1'b0);
    wait_done();
    check_eq("no_div_busy", {31'd0, mdu.busy}, 32'd0);
    tick();
    check_eq("no_div_busy2", {31'd0, mdu.busy}, 32'd0);

    issue(MDU_MULT, 32'd5, 32'd5, 1'b1);
    check_eq("req_start_busy", {31'd0, mdu.busy}, 32'd0);
    read_hilo(h, l);
    check_eq("req_start_hi", h, 32'd1);
    check_eq("req_start_lo", l, 32'd0);

    expect_op("div_req", 32'd2, 32'd14, 7);
    issue(MDU_DIV, 32'd100, 32'd7, 1'b0);
    mdu.req = 1'b1;
    tick();
    tick();
    tick();
    mdu.req = 1'b0;
    wait_done();

    mt(MDU_MTHI, 32'h1234_5678, 1'b0);
    read_hilo(h, l);
    check_eq("mthi_hi", h, 32'h1234_5678);
    check_eq("mthi_lo", l, 32'd14);
    mt(MDU_MTLO, 32'hCAFE_F00D, 1'b1);
    read_hilo(h, l);
    check_eq("mtlo_req_lo", l, 32'd14);
    mt(MDU_MTLO, 32'h0000_00A5, 1'b0);
    read_hilo(h, l);
    check_eq("mtlo_lo", l, 32'h0000_00A5);

    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      b = $urandom;
      p = {32'd0, a} * {32'd0, b};
      expect_op("rnd_multu", p[63:32], p[31:0], 5);
      issue(MDU_MULTU, a, b, 1'b0);
      wait_done();
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      p   = 64'(sa * sbv);
      expect_op("rnd_mult", p[63:32], p[31:0], 5);
      issue(MDU_MULT, a, b, 1'b0);
      wait_done();
      ia = $signed($urandom_range(200000, 0)) - 100000;
      ib = $signed($urandom_range(999, 1));
      if ($urandom_range(1, 0) == 1) ib = -ib;
      expect_op("rnd_div", 32'(ia % ib), 32'(ia / ib), 10);
      issue(MDU_DIV, 32'(ia), 32'(ib), 1'b0);
      wait_done();
    end

    // Reset two edges into a mult discards the pending result.
    issue(MDU_MULT, 32'd3, 32'd3, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rst_run_busy", {31'd0, mdu.busy}, 32'd0);
    read_hilo(h, l);
    check_eq("rst_run_hi", h, 32'd0);
    check_eq("rst_run_lo", l, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    read_hilo(h, l);
    check_eq("rst_nocommit_lo", l, 32'd0);

`ifdef MDU_MADD_EN
    mt(MDU_MTHI, 32'd0, 1'b0);
    mt(MDU_MTLO, 32'hFFFF_FFFF, 1'b0);
    expect_op("madd", 32'd1, 32'd0, 5);
    issue(MDU_MADD, 32'd1, 32'd1, 1'b0);
    wait_done();
    mt(MDU_MTHI, 32'd0, 1'b0);
    mt(MDU_MTLO, 32'd0, 1'b0);
    expect_op("msubu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    issue(MDU_MSUBU, 32'd1, 32'd1, 1'b0);
    wait_done();
`endif

    check_eq("sb_left", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
